vecflag_capture_fifo: RTL and testbench

- Downstream consumer of the 3x2 packed status vector and the 1-bit OR flag produced by the preceding combinational stage.
- Watches the {vector, flag} pair every cycle and pushes it into a small FIFO only when it changes (change-of-value capture).
- Presents captured entries to the next stage over a valid/ready handshake.
- Counts samples dropped while the FIFO is full and flags them with a sticky bit.

---
 rtl/vecflag_capture_fifo_if.sv | 23 ++
 rtl/vecflag_capture_fifo.sv | 104 ++++++++++
 tb/tb_vecflag_capture_fifo.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vecflag_capture_fifo_if.sv
// Stream bundle for the change-of-value capture FIFO: upstream status
// sample, capture enable, and the downstream valid/ready head entry.
interface vecflag_capture_fifo_if;
    logic [3:1][1:2] in_vec;
    logic            in_flag;
    logic            cap_en;
    logic            out_valid;
    logic            out_ready;
    logic [3:1][1:2] out_vec;
    logic            out_flag;

    // Driver/consumer side (testbench or neighbouring stages).
    modport master (
        output in_vec, in_flag, cap_en, out_ready,
        input  out_valid, out_vec, out_flag
    );

    // The capture FIFO itself.
    modport slave (
        input  in_vec, in_flag, cap_en, out_ready,
        output out_valid, out_vec, out_flag
    );
endinterface

// File: rtl/vecflag_capture_fifo.sv
// Change-of-value capture FIFO: pushes {in_vec,in_flag} only when it differs
// from the last captured value, presents entries over valid/ready, and
// counts (saturating) the changes dropped while the FIFO is full.
module vecflag_capture_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vecflag_capture_fifo_if.slave    bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         ovf_cnt,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] OCC_EMPTY   = 2'd0;
    localparam logic [1:0] OCC_PARTIAL = 2'd1;
    localparam logic [1:0] OCC_FULL    = 2'd2;

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          last_valid;
    logic [6:0]    last_q;
    logic [1:0]    occ;
    logic [6:0]    cur;
    logic          chg;
    logic          pop;
    logic          push;
    logic          drop;

    // Occupancy state is a pure function of level, so it can never disagree with it.
    always_comb begin
        // NOTE: default first so every path assigns occ and no latch is inferred.
        occ = OCC_PARTIAL;
        if (level == '0)
            occ = OCC_EMPTY;
        else if (level == LW'(DEPTH))
            occ = OCC_FULL;
    end

    assign cur  = {bus.in_vec, bus.in_flag};
    assign chg  = bus.cap_en && (!last_valid || cur != last_q);
    assign pop  = bus.out_valid && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = chg && (occ != OCC_FULL || pop);
    assign drop = chg && !push;

    assign bus.out_valid = (occ != OCC_EMPTY);
    assign bus.out_vec   = bus.out_valid ? mem[rptr][6:1] : '0;
    assign bus.out_flag  = bus.out_valid ? mem[rptr][0]   : 1'b0;

    // Pointers, occupancy and the last-captured comparison value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            last_valid <= 1'b0;
            last_q     <= '0;
        end else begin
            if (push) begin
                wptr       <= wptr + 1'b1;
                last_q     <= cur;
                last_valid <= 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Entry storage; contents are only visible through out_valid-gated outputs.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; reset clears pointers and level, which discards it.
        if (push)
            mem[wptr] <= cur;
    end

    // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)
                ovf_cnt <= CNT_W'(1);
            else if (ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end
    end
endmodule

// File: tb/tb_vecflag_capture_fifo.sv
// Directed self-checking bench for vecflag_capture_fifo.
module tb_vecflag_capture_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_ovf;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] ovf_cnt;
    int         n_checks = 0;
    int         n_fail   = 0;

    vecflag_capture_fifo_if bus ();

    vecflag_capture_fifo #(.DEPTH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .level    (level),
        .overflow (overflow),
        .ovf_cnt  (ovf_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic v, input logic [5:0] vec,
                              input logic flag, input logic [2:0] lvl);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".vec"},   32'(bus.out_vec),   32'(vec));
        check({tag, ".flag"},  32'(bus.out_flag),  32'(flag));
        check({tag, ".level"}, 32'(level),         32'(lvl));
    endtask

    task automatic check_ovf(input string tag, input logic ov, input logic [7:0] cnt);
        check({tag, ".overflow"}, 32'(overflow), 32'(ov));
        check({tag, ".ovf_cnt"},  32'(ovf_cnt),  32'(cnt));
    endtask

    initial begin
        rst_n         = 1'b0;
        clr_ovf       = 1'b0;
        bus.in_vec    = '0;
        bus.in_flag   = 1'b0;
        bus.cap_en    = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check_head("reset", 1'b0, 6'h00, 1'b0, 3'd0);
        check_ovf("reset", 1'b0, 8'd0);

        // Single capture of a held value.
        rst_n       = 1'b1;
        bus.in_vec  = 6'h15;
        bus.in_flag = 1'b1;
        bus.cap_en  = 1'b1;
        step();
        check_head("first_push", 1'b1, 6'h15, 1'b1, 3'd1);
        step();
        check_head("held_no_repush", 1'b1, 6'h15, 1'b1, 3'd1);

        // Pop it so the fill test starts empty.
        bus.out_ready = 1'b1;
        step();
        check_head("pop_to_empty", 1'b0, 6'h00, 1'b0, 3'd0);
        bus.out_ready = 1'b0;

        // Fill with 01..04, then 05 is dropped and counted each cycle it is held.
        bus.in_flag = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.in_vec = 6'(i);
            step();
        end
        check_head("full", 1'b1, 6'h01, 1'b0, 3'd4);
        check_ovf("full", 1'b0, 8'd0);
        bus.in_vec = 6'h05;
        step();
        check_ovf("drop1", 1'b1, 8'd1);
        check_head("drop1_stable", 1'b1, 6'h01, 1'b0, 3'd4);
        step();
        check_ovf("drop2", 1'b1, 8'd2);
        step();
        check_ovf("drop3", 1'b1, 8'd3);

        // Full with simultaneous pop and new value: both happen.
        bus.out_ready = 1'b1;
        bus.in_vec    = 6'h06;
        step();
        check_head("pop_push_full", 1'b1, 6'h02, 1'b0, 3'd4);
        check_ovf("pop_push_full", 1'b1, 8'd3);

        // Drain in order 02,03,04,06.
        step();
        check_head("drain1", 1'b1, 6'h03, 1'b0, 3'd3);
        step();
        check_head("drain2", 1'b1, 6'h04, 1'b0, 3'd2);
        step();
        check_head("drain3", 1'b1, 6'h06, 1'b0, 3'd1);
        step();
        check_head("drain_empty", 1'b0, 6'h00, 1'b0, 3'd0);
        bus.out_ready = 1'b0;

        // Refill with 07..0A, then clear in a cycle with a drop.
        for (int i = 7; i <= 10; i++) begin
            bus.in_vec = 6'(i);
            step();
        end
        check_head("refill", 1'b1, 6'h07, 1'b0, 3'd4);
        bus.in_vec = 6'h0B;
        clr_ovf    = 1'b1;
        step();
        check_ovf("clr_with_drop", 1'b1, 8'd1);
        bus.in_vec = 6'h0A;
        step();
        check_ovf("clr_no_drop", 1'b0, 8'd0);
        clr_ovf = 1'b0;

        // One pop to reach level 3, then asynchronous reset mid-cycle.
        bus.out_ready = 1'b1;
        step();
        check_head("pop_to_3", 1'b1, 6'h08, 1'b0, 3'd3);
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_head("async_reset", 1'b0, 6'h00, 1'b0, 3'd0);
        check_ovf("async_reset", 1'b0, 8'd0);
        #1;
        rst_n = 1'b1;
        step();
        check_head("recapture_after_reset", 1'b1, 6'h0A, 1'b0, 3'd1);

        // cap_en low blocks pushes; re-enabling on the last captured value does not push.
        bus.cap_en = 1'b0;
        bus.in_vec = 6'h0C;
        step();
        check_head("cap_en_off", 1'b1, 6'h0A, 1'b0, 3'd1);
        bus.in_vec = 6'h0A;
        bus.cap_en = 1'b1;
        step();
        check_head("reenable_same", 1'b1, 6'h0A, 1'b0, 3'd1);

        // Fill and hold a dropped value long enough to saturate the counter.
        for (int i = 13; i <= 15; i++) begin
            bus.in_vec = 6'(i);
            step();
        end
        bus.in_vec = 6'h10;
        for (int i = 0; i < 300; i++)
            step();
        check_ovf("saturate", 1'b1, 8'hFF);
        check_head("saturate", 1'b1, 6'h0A, 1'b0, 3'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
